mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-port memory: combinational grant, response one cycle later.
// Fixed data priority with fetch-starvation override; define ARB_RR_EN for round-robin between the ports.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                iReq,
    input  logic [ADDR_W-1:0]   iAddr,
    output logic                iGnt,
    output logic                iRvalid,
    output logic [DATA_W-1:0]   iRdata,
    input  logic                dReq,
    input  logic                dWen,
    input  logic [DATA_W/8-1:0] dBe,
    input  logic [ADDR_W-1:0]   dAddr,
    input  logic [DATA_W-1:0]   dWdata,
    input  logic                dLock,
    output logic                dGnt,
    output logic                dRvalid,
    output logic [DATA_W-1:0]   dRdata,
    output logic                memReq,
    output logic                memWen,
    output logic [DATA_W/8-1:0] memBe,
    output logic [ADDR_W-1:0]   memAddr,
    output logic [DATA_W-1:0]   memWdata,
    input  logic [DATA_W-1:0]   memRdata
);

    typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} owner_e;
    typedef enum logic {UNLOCKED, LOCKED} lock_e;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    owner_e     owner_q;
    lock_e      lock_q;
    logic [3:0] wait_cnt;
    logic       starve;
    logic       i_win;
    logic       d_win;

`ifdef ARB_RR_EN
    logic rr_ptr;   // 0 selects data, 1 selects instruction on a contested cycle
`endif

    always_comb begin
        i_win  = 1'b0;
        d_win  = 1'b0;
        // >= so a count that overran MAX_WAIT while locked still forces the fetch through
        starve = iReq && (wait_cnt >= MAX_WAIT_C);
        if (lock_q == LOCKED) begin
            d_win = dReq;
        end else if (starve) begin
            i_win = 1'b1;
        end else begin
`ifdef ARB_RR_EN
            if (iReq && dReq) begin
                d_win = ~rr_ptr;
                i_win = rr_ptr;
            end else begin
                d_win = dReq;
                i_win = iReq;
            end
`else
            d_win = dReq;
            i_win = iReq && !dReq;
`endif
        end
    end

    // Grants are gated by reset so every output is quiet while rstN is low
    assign iGnt     = i_win && rstN;
    assign dGnt     = d_win && rstN;
    assign memReq   = iGnt || dGnt;
    assign memWen   = dGnt ? dWen : 1'b0;
    assign memBe    = dGnt ? dBe : '0;
    assign memWdata = dGnt ? dWdata : '0;
    assign memAddr  = dGnt ? dAddr : (iGnt ? iAddr : '0);

    assign iRvalid  = (owner_q == OWN_INSTR);
    assign dRvalid  = (owner_q == OWN_DATA);
    assign iRdata   = iRvalid ? memRdata : '0;
    assign dRdata   = dRvalid ? memRdata : '0;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            owner_q <= OWN_NONE;
        end else if (dGnt) begin
            owner_q <= OWN_DATA;
        end else if (iGnt) begin
            owner_q <= OWN_INSTR;
        end else begin
            owner_q <= OWN_NONE;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wait_cnt <= 4'd0;
        end else if (iGnt || !iReq) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != 4'hF) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            lock_q <= UNLOCKED;
        end else begin
            case (lock_q)
                UNLOCKED: if (dGnt && dLock)  lock_q <= LOCKED;
                LOCKED:   if (dGnt && !dLock) lock_q <= UNLOCKED;
                default:  lock_q <= UNLOCKED;
            endcase
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rr_ptr <= 1'b0;
        end else if (dGnt) begin
            rr_ptr <= 1'b1;
        end else if (iGnt) begin
            rr_ptr <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter; expectations follow ARB_RR_EN when it is defined.
module tb_mem_arbiter;

    typedef logic [137:0] out_t;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [3:0]  dbe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        dl;
        logic [31:0] mrd;
        out_t        exp;
    } vec_t;

    logic        clk;
    logic        rstN;
    logic        iReq;
    logic [31:0] iAddr;
    logic        iGnt, iRvalid;
    logic [31:0] iRdata;
    logic        dReq, dWen, dLock;
    logic [3:0]  dBe;
    logic [31:0] dAddr, dWdata;
    logic        dGnt, dRvalid;
    logic [31:0] dRdata;
    logic        memReq, memWen;
    logic [3:0]  memBe;
    logic [31:0] memAddr, memWdata, memRdata;

    int n_checks = 0;
    int n_err    = 0;
    vec_t vq[$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rstN(rstN),
        .iReq(iReq), .iAddr(iAddr), .iGnt(iGnt), .iRvalid(iRvalid), .iRdata(iRdata),
        .dReq(dReq), .dWen(dWen), .dBe(dBe), .dAddr(dAddr), .dWdata(dWdata), .dLock(dLock),
        .dGnt(dGnt), .dRvalid(dRvalid), .dRdata(dRdata),
        .memReq(memReq), .memWen(memWen), .memBe(memBe), .memAddr(memAddr),
        .memWdata(memWdata), .memRdata(memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic out_t cur();
        return {iGnt, dGnt, memReq, memWen, memBe, memAddr, memWdata,
                iRvalid, iRdata, dRvalid, dRdata};
    endfunction

    function automatic out_t mkexp(input logic eI, input logic eD, input logic [31:0] ia,
                                   input logic dw, input logic [3:0] dbe, input logic [31:0] da,
                                   input logic [31:0] dwd, input logic eIrv, input logic eDrv,
                                   input logic [31:0] mrd);
        logic        wen;
        logic [3:0]  be;
        logic [31:0] a;
        logic [31:0] wd;
        wen = 1'b0; be = 4'h0; a = 32'h0; wd = 32'h0;
        if (eD) begin
            wen = dw; be = dbe; a = da; wd = dwd;
        end else if (eI) begin
            a = ia;
        end
        return {eI, eD, eI | eD, wen, be, a, wd,
                eIrv, eIrv ? mrd : 32'h0, eDrv, eDrv ? mrd : 32'h0};
    endfunction

    task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd,
                       input logic dl, input logic [31:0] mrd,
                       input logic eI, input logic eD, input logic eIrv, input logic eDrv);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.dbe = dbe; v.da = da;
        v.dwd = dwd; v.dl = dl; v.mrd = mrd;
        v.exp = mkexp(eI, eD, ia, dw, dbe, da, dwd, eIrv, eDrv, mrd);
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        iReq = v.ir; iAddr = v.ia; dReq = v.dr; dWen = v.dw; dBe = v.dbe;
        dAddr = v.da; dWdata = v.dwd; dLock = v.dl; memRdata = v.mrd;
    endtask

    task automatic idle_inputs();
        iReq = 0; iAddr = 0; dReq = 0; dWen = 0; dBe = 0; dAddr = 0; dWdata = 0; dLock = 0;
        memRdata = 0;
    endtask

    task automatic check(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // basic fetch, write, read, back-to-back
        add(0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,        0, 32'h0,        0, 0, 0, 0);
        add(1, 32'h100, 0, 0, 4'h0, 32'h0,  32'h0,        0, 32'h0,        1, 0, 0, 0);
        add(0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,        0, 32'hDEADBEEF, 0, 0, 1, 0);
        add(0, 32'h0,   1, 1, 4'h3, 32'h40, 32'h12345678, 0, 32'h0,        0, 1, 0, 0);
        add(0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,        0, 32'hAAAA5555, 0, 0, 0, 1);
        add(0, 32'h0,   1, 0, 4'hF, 32'h44, 32'h0,        0, 32'h0,        0, 1, 0, 0);
        add(1, 32'h104, 0, 0, 4'h0, 32'h0,  32'h0,        0, 32'h11112222, 1, 0, 0, 1);
        add(0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,        0, 32'h33334444, 0, 0, 1, 0);
        // both ports held
`ifndef ARB_RR_EN
        add(1, 32'h108, 1, 0, 4'hF, 32'h48, 32'h0, 0, 32'h00000D0D, 0, 1, 0, 0);
        add(1, 32'h108, 1, 0, 4'hF, 32'h48, 32'h0, 0, 32'h00000D0D, 0, 1, 0, 1);
        add(1, 32'h108, 1, 0, 4'hF, 32'h48, 32'h0, 0, 32'h00000D0D, 0, 1, 0, 1);
        add(1, 32'h108, 1, 0, 4'hF, 32'h48, 32'h0, 0, 32'h00000D0D, 0, 1, 0, 1);
        add(1, 32'h108, 1, 0, 4'hF, 32'h48, 32'h0, 0, 32'h00000D0D, 1, 0, 0, 1);
        add(1, 32'h108, 1, 0, 4'hF, 32'h48, 32'h0, 0, 32'h0E0E0E0E, 0, 1, 1, 0);
        add(0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0, 0, 32'h0F0F0F0F, 0, 0, 0, 1);
`else
        add(1, 32'h108, 1, 0, 4'hF, 32'h48, 32'h0, 0, 32'h00000D0D, 0, 1, 0, 0);
        add(1, 32'h108, 1, 0, 4'hF, 32'h48, 32'h0, 0, 32'h00000D0D, 1, 0, 0, 1);
        add(1, 32'h108, 1, 0, 4'hF, 32'h48, 32'h0, 0, 32'h00000D0D, 0, 1, 1, 0);
        add(1, 32'h108, 1, 0, 4'hF, 32'h48, 32'h0, 0, 32'h00000D0D, 1, 0, 0, 1);
        add(1, 32'h108, 1, 0, 4'hF, 32'h48, 32'h0, 0, 32'h00000D0D, 0, 1, 1, 0);
        add(1, 32'h108, 1, 0, 4'hF, 32'h48, 32'h0, 0, 32'h0E0E0E0E, 1, 0, 0, 1);
        add(0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0, 0, 32'h0F0F0F0F, 0, 0, 1, 0);
`endif
        // locked read-modify-write with fetch held; lock outlasts the starvation limit
        add(1, 32'h10C, 1, 1, 4'hF, 32'h200, 32'hCAFEF00D, 1, 32'h0, 0, 1, 0, 0);
        add(1, 32'h10C, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0, 0, 0, 0, 1);
        add(1, 32'h10C, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0, 0, 0, 0, 0);
        add(1, 32'h10C, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0, 0, 0, 0, 0);
        add(1, 32'h10C, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0, 0, 0, 0, 0);
        add(1, 32'h10C, 1, 0, 4'hF, 32'h200, 32'h0,        0, 32'h0, 0, 1, 0, 0);
        add(1, 32'h10C, 0, 0, 4'h0, 32'h0,   32'h0,        0, 32'hCAFEF00D, 1, 0, 0, 1);
        add(0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h00000001, 0, 0, 1, 0);

        // reset state with both requests asserted
        rstN = 1'b0;
        iReq = 1; iAddr = 32'h500; dReq = 1; dWen = 1; dBe = 4'hF; dAddr = 32'h600;
        dWdata = 32'h55; dLock = 1; memRdata = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check("reset_outputs", cur(), '0);
        idle_inputs();
        rstN = 1'b1;

        for (int k = 0; k < vq.size(); k++) begin
            @(negedge clk);
            drive(vq[k]);
            #1 check($sformatf("vec%0d", k), cur(), vq[k].exp);
        end

        // reset lands in the response cycle of a data grant
        @(negedge clk);
        idle_inputs();
        dReq = 1; dBe = 4'hF; dAddr = 32'h300;
        #1 check("pre_reset_dgnt", cur(),
                 mkexp(0, 1, 32'h0, 0, 4'hF, 32'h300, 32'h0, 0, 0, 32'h0));
        @(negedge clk);
        dReq = 0; memRdata = 32'h77; rstN = 1'b0;
        #1 check("reset_mid_access", cur(), '0);
        @(negedge clk);
        iReq = 1; iAddr = 32'h400; dReq = 1; dAddr = 32'h300;
        #1 check("reset_hold", cur(), '0);
        @(negedge clk);
        idle_inputs();
        memRdata = 32'h77; iReq = 1; iAddr = 32'h400; rstN = 1'b1;
        #1 check("first_grant_after_reset", cur(),
                 mkexp(1, 0, 32'h400, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h77));
        @(negedge clk);
        idle_inputs();
        memRdata = 32'h99;
        #1 check("response_after_reset", cur(),
                 mkexp(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h99));
        @(negedge clk);
        #1 check("idle_after_reset", cur(), '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
